// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and elaboration helpers
// for the digit-serial adder (clog2, counter width, W/D legality).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit wd_ok(input int w, input int d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_add_digit.sv
// add_digit: D-bit ripple of full-adder cells.
// Ports: a, b, ci in; s (sum digit), co (carry out), cm (carry into MSB).
module add_digit #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         ci,
  output logic [D-1:0] s,
  output logic         co,
  output logic         cm
);

  always_comb begin
    logic [D:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < D; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[D];
    cm = c[D-1];
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: W-bit add over W/D cycles, D bits/cycle, LSB first.
// Ports: clk, rst_b, start, x, y, ci (+sub with SERIAL_ADDER_SUB_EN)
// in; busy, done, z, co, ovf out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         co,
  output logic         ovf
);

  localparam int N  = W / D;
  localparam int CW = cnt_w(N);

  if (!wd_ok(W, D)) begin : g_bad_wd
    $error("serial_adder: W must be a multiple of D");
  end

  state_t         st, st_nxt;
  logic [W-1:0]   xs, ys, zs, z_nxt, y_ld;
  logic           cr;
  logic [CW-1:0]  cnt;
  logic [D-1:0]   sd;
  logic           dco, dcm;
  logic           acc, last;

`ifdef SERIAL_ADDER_SUB_EN
  // ~y with carry-in ci gives x - y - ~ci
  assign y_ld = sub ? ~y : y;
`else
  assign y_ld = y;
`endif

  assign acc  = start && (st != S_RUN);
  assign last = (cnt == CW'(N - 1));
  assign busy = (st == S_RUN);
  assign done = (st == S_DONE);

  add_digit #(.D(D)) u_dig (
    .a  (xs[D-1:0]),
    .b  (ys[D-1:0]),
    .ci (cr),
    .s  (sd),
    .co (dco),
    .cm (dcm)
  );

  // New digit enters the sum register at the MSB end
  if (D == W) begin : g_full
    assign z_nxt = sd;
  end else begin : g_part
    assign z_nxt = {sd, zs[W-1:D]};
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:  if (start) st_nxt = S_RUN;
      S_RUN:   if (last)  st_nxt = S_DONE;
      S_DONE:  st_nxt = start ? S_RUN : S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      xs  <= '0;
      ys  <= '0;
      zs  <= '0;
      cr  <= 1'b0;
      cnt <= '0;
      z   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else if (acc) begin
      xs  <= x;
      ys  <= y_ld;
      cr  <= ci;
      cnt <= '0;
    end else if (st == S_RUN) begin
      xs  <= xs >> D;
      ys  <= ys >> D;
      zs  <= z_nxt;
      cr  <= dco;
      cnt <= cnt + 1'b1;
      if (last) begin
        z   <= z_nxt;
        co  <= dco;
        ovf <= dcm ^ dco;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand sequences and random sweep
// over several W/D configurations against an arithmetic model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] xb = '0;
  logic [15:0] yb = '0;

  always #5 clk = ~clk;

  logic       b0, d0, c0, v0;
  logic [7:0] z0;
  logic       b1, d1, c1, v1;
  logic [7:0] z1;
  logic       b2, d2, c2, v2;
  logic [7:0] z2;
  logic       b3, d3, c3, v3;
  logic [7:0] z3;
  logic       b4, d4, c4, v4;
  logic [15:0] z4;

  serial_adder #(.W(8), .D(2)) u0 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x(xb[7:0]), .y(yb[7:0]), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(b0), .done(d0), .z(z0), .co(c0), .ovf(v0)
  );

  serial_adder #(.W(8), .D(1)) u1 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x(xb[7:0]), .y(yb[7:0]), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(b1), .done(d1), .z(z1), .co(c1), .ovf(v1)
  );

  serial_adder #(.W(8), .D(4)) u2 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x(xb[7:0]), .y(yb[7:0]), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(b2), .done(d2), .z(z2), .co(c2), .ovf(v2)
  );

  serial_adder #(.W(8), .D(8)) u3 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x(xb[7:0]), .y(yb[7:0]), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(b3), .done(d3), .z(z3), .co(c3), .ovf(v3)
  );

  serial_adder #(.W(16), .D(4)) u4 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x(xb), .y(yb), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(b4), .done(d4), .z(z4), .co(c4), .ovf(v4)
  );

  int n_vec = 0;
  int n_bad = 0;
  int nd0 = 0;

  always @(posedge clk) if (d0) nd0++;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       c;
    logic [7:0] z;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Returns {ovf, co, z} from plain integer arithmetic
  function automatic longint model(input int w, input longint x,
                                   input longint y, input bit c,
                                   input bit sb);
    longint m, h, sx, sy, u, sr;
    bit     cout, ov;
    m  = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    sx = (x >= h) ? x - 2 * h : x;
    sy = (y >= h) ? y - 2 * h : y;
    if (sb) begin
      u    = x - y - (1 - longint'(c));
      sr   = sx - sy - (1 - longint'(c));
      cout = (u >= 0);
    end else begin
      u    = x + y + longint'(c);
      sr   = sx + sy + longint'(c);
      cout = (u > m);
    end
    ov = (sr < -h) || (sr >= h);
    return (longint'(ov) << (w + 1)) | (longint'(cout) << w) | (u & m);
  endfunction

  task automatic op(input logic [15:0] x, input logic [15:0] y,
                    input logic c, input logic sb);
    @(negedge clk);
    xb = x;
    yb = y;
    ci = c;
    sub = sb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_wait(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (!d0 && lat < 20) begin
      bc += int'(b0);
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, s;
    logic [15:0] rx, ry;
    logic rc, rs;

    tbl[0] = '{8'h3A, 8'h25, 1'b0, 8'h5F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_state", {b0, d0, v0, c0, z0}, 0);
    rst_b = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op({8'h00, tbl[i].x}, {8'h00, tbl[i].y}, tbl[i].c, 1'b0);
      run_wait(lat, bc);
      chk($sformatf("latency[%0d]", i), lat, 4);
      chk($sformatf("busy_cycles[%0d]", i), bc, 4);
      chk($sformatf("result[%0d]", i), {v0, c0, z0},
          {tbl[i].ov, tbl[i].co, tbl[i].z});
      @(negedge clk);
      chk($sformatf("done_pulse[%0d]", i), d0, 0);
    end

    op(16'h12, 16'h34, 1'b0, 1'b0);
    run_wait(lat, bc);
    chk("b2b_first", {v0, c0, z0}, {1'b0, 1'b0, 8'h46});
    xb = 16'hA0;
    yb = 16'h70;
    ci = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait(lat, bc);
    chk("b2b_gap", lat + 1, 5);
    chk("b2b_second", {v0, c0, z0}, {1'b0, 1'b1, 8'h10});

    repeat (3) @(negedge clk);
    s = nd0;
    op(16'h01, 16'h02, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("run_start_ignored", nd0 - s, 1);
    chk("run_start_result", {v0, c0, z0}, {1'b0, 1'b0, 8'h03});

    s = nd0;
    op(16'h55, 16'h0F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("reset_mid_outs", {b0, d0, v0, c0, z0}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (8) @(negedge clk);
    chk("reset_mid_no_done", nd0 - s, 0);
    chk("reset_mid_z_hold", {v0, c0, z0}, 0);

`ifdef SERIAL_ADDER_SUB_EN
    op(16'h10, 16'h20, 1'b1, 1'b1);
    run_wait(lat, bc);
    chk("sub_basic", {v0, c0, z0}, {1'b0, 1'b0, 8'hF0});
    repeat (2) @(negedge clk);
`endif

    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      op(rx, ry, rc, rs);
      repeat (10) @(negedge clk);
      chk("rnd_w8_d2", {v0, c0, z0},
          model(8, longint'(rx[7:0]), longint'(ry[7:0]), rc, rs));
      chk("rnd_w8_d1", {v1, c1, z1},
          model(8, longint'(rx[7:0]), longint'(ry[7:0]), rc, rs));
      chk("rnd_w8_d4", {v2, c2, z2},
          model(8, longint'(rx[7:0]), longint'(ry[7:0]), rc, rs));
      chk("rnd_w8_d8", {v3, c3, z3},
          model(8, longint'(rx[7:0]), longint'(ry[7:0]), rc, rs));
      chk("rnd_w16_d4", {v4, c4, z4},
          model(16, longint'(rx), longint'(ry), rc, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised digit-serial adder.
- Adds two W-bit operands plus carry-in over W/D clock cycles, D bits per cycle, LSB digit first.
- Uses a chain of D full-adder cells.
- Start/busy/done handshake; registered sum, carry-out and signed overflow.
- Datapath building block for the multi-cycle ALU exercises; trades area for latency against a full-width ripple adder.

Parameters:
- W, 8, operand/sum width in bits; must be a multiple of D.
- D, 2, digit width (bits added per cycle); 1 <= D <= W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready.
- x  input  W  operand A; captured on accepted start.
- y  input  W  operand B; captured on accepted start.
- ci  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse; z/co/ovf valid.
- z  output  W  sum.
- co  output  1  unsigned carry-out.
- ovf  output  1  signed (two's complement) overflow.

Behaviour:
- Interface decision: one clock, clk; reset rst_b is asynchronous and active-low.
- Reset (rst_b=0, any time): state=IDLE; busy=0, done=0, z=0, co=0, ovf=0; internal registers and digit counter cleared.
- Reset mid-operation aborts the operation: no done pulse, results discarded.
- Constants: N = W/D cycles per operation. Counter width = clog2(N), minimum 1.
- IDLE: ready. If start=1 at an edge:
  - latch x, y into shift registers;
  - carry register <= ci; cnt <= 0; go to RUN; busy=1 from next cycle.
- RUN: each edge adds digit cnt, i.e. bits [cnt*D +: D], through D chained cells using the carry register as carry-in.
  - Result digit is shifted into the z register from the MSB end.
  - Carry register <= carry out of the chain.
  - cnt <= cnt+1.
  - start is ignored in RUN.
- Last digit edge (cnt = N-1):
  - co <= final carry;
  - ovf <= carry into bit W-1 XOR carry out of bit W-1;
  - state <= DONE.
- DONE: lasts exactly one cycle.
  - done=1, busy=0; z/co/ovf hold the final result.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation, no bubble); otherwise go to IDLE.
- Latency: done is high N cycles after the edge that accepted start (W=8, D=2: 4 cycles).
  - Throughput: one operation per N+1 cycles back-to-back.
- Output hold: z/co/ovf hold the last result in IDLE until the next operation completes. They are not updated visibly during RUN; the z shift register is internal and is copied to z at the last edge.
- Degenerate D=W: N=1; RUN lasts one cycle; done is high 1 cycle after start.
- Inputs x/y/ci may change freely after acceptance.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - extra input port sub (1 bit), captured with the operands;
  - sub=1 computes x - y - (~ci): the y register is loaded with ~y and the carry register with ci.
  - Convention: ci=1 means "no borrow", so sub=1, ci=1 gives x - y.
  - co is then the not-borrow flag; ovf is the signed subtraction overflow.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package/include serial_adder_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - helper function clog2;
  - parameter legality check (W % D == 0) raised as an elaboration error.
- One sub-module, add_digit (parameter D): combinational D-bit ripple of full-adder cells.
  - Outputs: sum digit, carry out, and carry into its MSB (needed for ovf on the last digit).

Test Plan:
- Reset mid-operation (W=8, D=2): start with x=8'h55, y=8'h0F; assert rst_b=0 after 2 cycles -> all outputs 0, IDLE, no done pulse.
- Basic add: x=8'h3A, y=8'h25, ci=0 -> done after 4 cycles; z=8'h5F, co=0, ovf=0; busy high exactly 4 cycles.
- Carry and wrap: x=8'hFF, y=8'h01, ci=0 -> z=8'h00, co=1, ovf=0. Then x=8'hFF, y=8'hFF, ci=1 -> z=8'hFF, co=1.
- Signed overflow: x=8'h7F, y=8'h01 -> z=8'h80, ovf=1, co=0. Then x=8'h80, y=8'h80 -> z=8'h00, ovf=1, co=1.
- Back-to-back: hold start=1 with new operands during the DONE cycle -> second done exactly 5 cycles after the first. A start pulsed during RUN is ignored and yields no extra done.
- Parameter sweep: D=1, 4, 8 (W=8) and W=16, D=4 against a golden {co, z} = x+y+ci over 1000 random vectors. With SERIAL_ADDER_SUB_EN: x=8'h10, y=8'h20, sub=1, ci=1 -> z=8'hF0, co=0.
